// File: rtl/lii_pkg.sv
// Shared LII definitions: id width and arbiter state encoding.
package lii_pkg;

    localparam int LII_ID_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lii_out_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             any_vld
);

    // Scan from ptr upward with wrap; the first valid index wins
    always_comb begin
        winner  = '0;
        any_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!any_vld && req[idx]) begin
                winner[idx] = 1'b1;
                any_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lii_out_arbiter.sv
// Round-robin burst arbiter sharing one LII phy output channel between NREQ
// kernel-wrapper streams; beats are tagged with src/dst and registered once.
module lii_out_arbiter
    import lii_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PW    = 1024,
    parameter int BURST = 4
) (
    input  logic                     aclk,
    input  logic                     arstn,
    input  logic [NREQ*PW-1:0]       req_tdata,
    input  logic [NREQ-1:0]          req_tvalid,
    output logic [NREQ-1:0]          req_tready,
    input  logic [NREQ-1:0]          req_tlast,
    input  logic [NREQ*LII_ID_W-1:0] req_src,
    input  logic [NREQ*LII_ID_W-1:0] req_dst,
    output logic [PW-1:0]            lii_out_p0_tdata,
    output logic                     lii_out_p0_tvalid,
    input  logic                     lii_out_p0_tready,
    output logic [LII_ID_W-1:0]      lii_out_p0_src,
    output logic [LII_ID_W-1:0]      lii_out_p0_dst,
    output logic [NREQ-1:0]          grant,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

    arb_state_t          state, state_nxt;
    logic [NREQ-1:0]     grant_q, grant_nxt, pick;
    logic [PTR_W-1:0]    ptr, ptr_nxt, gidx;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                pick_any, out_ready, accept, g_last;

    logic [PW-1:0]       out_tdata_p1;
    logic [LII_ID_W-1:0] out_src_p1, out_dst_p1;
    logic                vld_p1;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (req_tvalid),
        .ptr     (ptr),
        .winner  (pick),
        .any_vld (pick_any)
    );

    // Turn the one-hot grant into an index for slice selection
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) gidx = PTR_W'(i);
        end
    end

    // Winner may move a beat whenever the output register is empty or draining
    assign out_ready  = !vld_p1 || lii_out_p0_tready;
    assign req_tready = (state == GRANT && out_ready) ? grant_q : '0;
    assign accept     = |(req_tvalid & req_tready);
    assign g_last     = req_tlast[gidx];

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_nxt = cnt + 1'b1;
                    if (g_last || cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                        ptr_nxt   = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: FSM state, grant, round-robin pointer, beat counter
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Output stage: load the winner's beat on accept, empty once the phy takes it
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            vld_p1       <= 1'b0;
            out_tdata_p1 <= '0;
            out_src_p1   <= '0;
            out_dst_p1   <= '0;
        end else if (accept) begin
            vld_p1       <= 1'b1;
            out_tdata_p1 <= req_tdata[int'(gidx)*PW +: PW];
            out_src_p1   <= req_src[int'(gidx)*LII_ID_W +: LII_ID_W];
            out_dst_p1   <= req_dst[int'(gidx)*LII_ID_W +: LII_ID_W];
        end else if (lii_out_p0_tready) begin
            vld_p1       <= 1'b0;
        end
    end

    assign lii_out_p0_tdata  = out_tdata_p1;
    assign lii_out_p0_tvalid = vld_p1;
    assign lii_out_p0_src    = out_src_p1;
    assign lii_out_p0_dst    = out_dst_p1;
    assign grant             = grant_q;
    assign busy              = (state == GRANT);

endmodule

// File: doc/lii_out_arbiter.md
Name: lii_out_arbiter

Overview:
- Round-robin arbiter that shares one LII phy output channel (lii_out_p0_*) between NREQ kernel-wrapper output streams.
- Grants one requester at a time and holds the grant for a burst: up to BURST beats, or until that requester's tlast.
- Tags each beat with the winner's src/dst and drives it through a single output register stage.
- Sits between the per-kernel wrappers and the phy output port of a region.

Parameters:
- NREQ, 4, number of requesting streams (2..16)
- PW, 1024, packing width of the LII data bus
- BURST, 4, maximum beats per grant (1..256)

Ports:
- aclk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- req_tdata  in  NREQ*PW  requester data; slice i = [i*PW +: PW]
- req_tvalid  in  NREQ  requester valid
- req_tready  out  NREQ  requester ready
- req_tlast  in  NREQ  last beat of requester packet; ends grant
- req_src  in  NREQ*8  requester source id; slice i = [i*8 +: 8]
- req_dst  in  NREQ*8  requester destination id
- lii_out_p0_tdata  out  PW  phy data
- lii_out_p0_tvalid  out  1  phy valid
- lii_out_p0_tready  in  1  phy ready
- lii_out_p0_src  out  8  phy source id
- lii_out_p0_dst  out  8  phy destination id
- grant  out  NREQ  one-hot current grant; all zero when idle
- busy  out  1  high while in GRANT state

Behaviour:
- Reset (arstn low, asynchronous):
  - all outputs 0
  - state=IDLE, rr pointer=0, beat counter=0, output register empty
- FSM has two states: IDLE and GRANT.
- IDLE:
  - Search req_tvalid starting at index ptr, wrapping modulo NREQ; the first set bit wins.
  - If any valid: register grant one-hot, clear counter, go to GRANT next cycle.
  - req_tready all 0 in IDLE; this gives a one-cycle arbitration bubble per grant.
- GRANT (winner g):
  - req_tready[g] = !lii_out_p0_tvalid | lii_out_p0_tready; all other req_tready = 0.
  - Accept = req_tvalid[g] & req_tready[g].
  - On accept, the output register loads tdata/src/dst of slice g and sets tvalid=1.
  - Latency: a beat accepted at edge t is on lii_out_p0_* from t+1.
  - If the register holds a beat, lii_out_p0_tready=1 and there is no new accept, tvalid clears.
  - Output data/src/dst must stay stable while tvalid=1 and tready=0.
  - Counter increments on each accept.
  - Release on the accept where req_tlast[g]=1 or counter==BURST-1. On release: ptr=(g+1) mod NREQ, grant=0, state=IDLE next cycle.
  - If req_tvalid[g] drops mid-burst, the grant is held; there is no timeout or preemption.
  - Requesters other than g are never accepted, regardless of tvalid.
- Boundary cases:
  - BURST=1: release on every beat.
  - tlast on the first beat: release after that single beat.
  - Pointer wrap: after g=NREQ-1, ptr=0.
  - Only one requester valid: it is re-granted after each bubble.
  - Output back-pressure: req_tready[g]=0 while the register is full and lii_out_p0_tready=0; no beat is dropped or duplicated.
  - A beat still in the output register at release drains normally in IDLE/next GRANT.
  - Reset mid-burst: the pending output beat is discarded and lii_out_p0_tvalid goes 0 immediately.
- Width rules:
  - Counter width is clog2(BURST), minimum 1.
  - Pointer width is clog2(NREQ).

Decomposition:
- Shared package (lii_pkg): LII_ID_W=8 and the state enum {IDLE, GRANT}.
- One natural sub-module: rr_pick. It is combinational: inputs are the req vector and ptr; outputs are a one-hot winner and an any-valid flag.
- FSM, counter and output register stay in the top module.

Test Plan:
- Reset/idle: arstn low for 3 cycles with all req_tvalid=1 → lii_out_p0_tvalid=0, grant=0, busy=0. After release, grant=4'b0001 one cycle later.
- Round-robin, NREQ=4, BURST=4:
  - All four requesters stream 8-beat packets; lii_out_p0_tready=1.
  - Expect grant order 0,1,2,3,0…, 4 beats per grant, one bubble cycle between grants.
  - Expect lii_out_p0_src equal to the driven ids 8'h10..8'h13.
- tlast early release: requester 2 sends tlast on beat 2 while requesters 0 and 3 are valid, with ptr=2 → grant releases after 2 beats; next grant=4'b1000.
- Back-pressure: lii_out_p0_tready toggles 1,0,0,1 during a burst → output data held stable while stalled; beat sequence on the phy equals the input sequence with no loss or duplication.
- Stalled winner: requester 1 drops tvalid for 5 cycles mid-burst while requester 0 is valid → grant stays 4'b0010 and requester 0's req_tready stays 0; the burst completes at 4 beats.
- Reset mid-burst: assert arstn while tvalid=1 and tready=0 → lii_out_p0_tvalid=0 immediately; ptr=0 after reset.
